piso_serializer: RTL

Parallel-in, serial-out word serializer that sits directly upstream of the 4-bit serial-in/parallel-out shift register and drives its serial input. It accepts WIDTH-bit words on a valid/ready handshake, buffers one word while another is being shifted, and emits a continuous bitstream with a per-bit valid and a first-bit marker. When sout_first is used to align the downstream register, the original words can be rebuilt from its parallel output.

---
 rtl/piso_serializer.sv | 112 +++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in, serial-out word serializer. It double-buffers words
//            so the output bitstream is continuous, and marks each word's
//            first bit.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first
);

    localparam int              c_CW    = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(WIDTH - 1);
    localparam logic [0:0]      c_IDLE  = 1'b0;
    localparam logic [0:0]      c_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shift;
    logic [c_CW-1:0]  r_cnt;
    logic             r_first;

    logic             w_accept;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;

    assign w_accept = din_valid & ~r_hold_full;
    assign w_last   = (r_state == c_SHIFT) && (r_cnt == c_LAST);
    // A transfer happens from IDLE, or at the end of a word, but only if a word is held.
    assign w_load   = r_hold_full & ((r_state == c_IDLE) | w_last);

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
            assign w_out_bit = r_shift[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
            assign w_out_bit = r_shift[0];
        end
    endgenerate

    // State register plus datapath registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= c_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_first     <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_hold      <= din;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_shift <= r_hold;
                r_cnt   <= '0;
                r_first <= 1'b1;
            end else if (w_last) begin
                // Clearing here keeps sout low throughout IDLE.
                r_shift <= '0;
                r_cnt   <= '0;
                r_first <= 1'b0;
            end else if (r_state == c_SHIFT) begin
                r_shift <= w_shifted;
                r_cnt   <= r_cnt + 1'b1;
                r_first <= 1'b0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (r_hold_full) w_next_state = c_SHIFT;
            c_SHIFT: if (w_last && !r_hold_full) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output decode, which is driven from registers only
    always_comb begin
        din_ready  = ~r_hold_full;
        sout       = w_out_bit;
        sout_valid = (r_state == c_SHIFT);
        sout_first = r_first;
    end

endmodule
`default_nettype wire
